lv1_delay_ctrl: RTL and testbench
=================================

// Module: lv1_delay_ctrl
// PURPOSE
//  Spill sequencer for the L1-delay measurement block: drives its live window,
//  ena_delta time base and gated lv1. After each spill it reads back the
//  measured delay and reports it, with a timeout flag and L1 count, over a
//  valid/ready handshake to the register/readout side.
// PARAMETERS
//  DELTA_DIV  4     clk cycles per ena_delta tick (>=2)
//  CNT_W      10    width of delay / tick counters
//  TIMEOUT    1022  ticks with no first L1 before rpt_timeout is set
//  DEAD_MIN   2     min clk cycles live stays low between spills (>=2)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  spill_on     in   1      spill request level (synchronous to clk)
//  lv1_in       in   1      raw L1 trigger, 1-cycle pulses
//  meas_delay   in   CNT_W  delay value from the measurement block
//  live         out  1      live window to the measurement block
//  ena_delta    out  1      1-cycle tick to the measurement block
//  lv1          out  1      L1 forwarded only while live
//  rpt_valid    out  1      report available
//  rpt_delay    out  CNT_W  captured delay
//  rpt_timeout  out  1      no L1 within TIMEOUT ticks of this spill
//  rpt_lv1_cnt  out  16     L1 count in this spill, saturating at 16'hFFFF
//  rpt_ready    in   1      report accepted
// BEHAVIOUR
//  Reset: the clock and reset are as stated above: one clock, clk; reset
//   rst_n is asynchronous and active-low. On reset all outputs = 0, state =
//   DEAD, and dead_cnt, tick_cnt and the prescaler = 0. Reset mid-spill drops
//   live immediately, discards the report and issues no rpt_valid.
//  FSM states: DEAD, IDLE, LIVE, SETTLE, REPORT. All outputs are registered.
//   DEAD: live=0. dead_cnt counts up. Go to IDLE when dead_cnt==DEAD_MIN-1.
//   IDLE: live=0. On spill_on==1, go to LIVE. Entering LIVE clears the
//    prescaler, tick_cnt, lv1 count and the first-L1 flag.
//   LIVE: live=1.
//    - Prescaler counts 0..DELTA_DIV-1 and wraps. ena_delta=1 in the cycle
//      after the prescaler hits DELTA_DIV-1, so the first tick comes
//      DELTA_DIV cycles after live rises.
//    - tick_cnt increments on each ena_delta until the first L1, saturating
//      at 2^CNT_W-1.
//    - lv1 = lv1_in delayed 1 cycle, gated by state==LIVE.
//    - Each forwarded L1 increments the lv1 count (saturating) and sets the
//      first-L1 flag.
//    - Timeout flag sets when tick_cnt reaches TIMEOUT and the flag is clear.
//    - On spill_on==0, go to SETTLE. live falls on that edge.
//   SETTLE: live=0, lv1=0, ena_delta=0. Lasts 2 cycles so meas_delay
//    reflects any last-cycle L1. Then capture meas_delay, the timeout flag and
//    the count into rpt_*, and go to REPORT.
//   REPORT: rpt_valid=1, rpt_* stable. On rpt_valid&&rpt_ready: rpt_valid=0
//    next cycle, go to DEAD. spill_on is ignored here; a new spill waits until
//    IDLE after the dead time.
//  Simultaneous events:
//   - lv1_in in the same cycle spill_on falls is forwarded, because lv1 is
//     registered from LIVE.
//   - L1 arriving on the tick that would set timeout: L1 wins, flag stays 0.
//  A spill_on pulse of 1 cycle still yields a full LIVE(1)/SETTLE/REPORT pass.
// TESTING
//  1 DELTA_DIV=4. spill_on high 200 cyc. lv1_in at cyc 41 after live rise
//    -> 10 ena_delta pulses precede lv1. rpt_valid with rpt_delay=meas_delay,
//    rpt_timeout=0, rpt_lv1_cnt=1.
//  2 TIMEOUT=5. No lv1_in for 40 cyc of live -> rpt_timeout=1 and
//    rpt_lv1_cnt=0 in the report.
//  3 Three lv1_in pulses in LIVE plus one in IDLE -> lv1 pulses exactly 3x,
//    rpt_lv1_cnt=3.
//  4 rpt_ready held 0 for 20 cyc with spill_on re-asserted -> live stays 0.
//    After ack, live rises no sooner than DEAD_MIN+1 cycles later.
//  5 rst_n low mid-LIVE -> live, ena_delta, lv1 and rpt_valid are 0
//    immediately. After release, no report issues until a new spill completes.
//  6 spill_on high for 1 cycle -> live high exactly 1 cycle, one report with
//    rpt_lv1_cnt=0.

Source files
------------

// File: rtl/lv1_delay_ctrl.sv
// lv1_delay_ctrl: spill sequencer for the L1-delay measurement block.
// It opens the live window, generates the ena_delta time base, and forwards
// gated L1 triggers. After each spill it reports the measured delay, a
// timeout flag and the L1 count over a valid/ready handshake.
module lv1_delay_ctrl #(
    parameter int DELTA_DIV = 4,
    parameter int CNT_W     = 10,
    parameter int TIMEOUT   = 1022,
    parameter int DEAD_MIN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spill_on,
    input  logic             lv1_in,
    input  logic [CNT_W-1:0] meas_delay,
    output logic             live,
    output logic             ena_delta,
    output logic             lv1,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_delay,
    output logic             rpt_timeout,
    output logic [15:0]      rpt_lv1_cnt,
    input  logic             rpt_ready
);

    localparam int PRE_W  = (DELTA_DIV > 1) ? $clog2(DELTA_DIV) : 1;
    localparam int DEAD_W = (DEAD_MIN > 1) ? $clog2(DEAD_MIN) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST      = PRE_W'(DELTA_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST     = DEAD_W'(DEAD_MIN - 1);
    localparam logic [CNT_W-1:0]  TICK_MAX      = '1;
    localparam logic [CNT_W-1:0]  TIMEOUT_TICKS = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_DEAD,
        S_IDLE,
        S_LIVE,
        S_SETTLE,
        S_REPORT
    } state_t;

    state_t            state, state_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
    logic              settle_cnt, settle_cnt_nxt;
    logic [PRE_W-1:0]  presc, presc_nxt;
    logic [CNT_W-1:0]  tick_cnt, tick_cnt_nxt;
    logic [15:0]       l1_cnt, l1_cnt_nxt;
    logic              first_l1, first_l1_nxt;
    logic              timeout_flag, timeout_flag_nxt;
    logic              live_nxt, ena_delta_nxt, lv1_nxt, rpt_valid_nxt;
    logic [CNT_W-1:0]  rpt_delay_nxt;
    logic              rpt_timeout_nxt;
    logic [15:0]       rpt_lv1_cnt_nxt;

    // A tick only counts when the spill continues, so no ena_delta leaks
    // into SETTLE; an L1 is forwarded only when sampled in LIVE.
    logic             tick;
    logic             l1_fwd;
    logic [CNT_W-1:0] tick_inc;

    assign l1_fwd   = (state == S_LIVE) && lv1_in;
    assign tick     = (state == S_LIVE) && spill_on && (presc == PRE_LAST);
    assign tick_inc = (tick_cnt == TICK_MAX) ? tick_cnt : tick_cnt + 1'b1;

    // Registers every state bit and every output; reset clears all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_DEAD;
            dead_cnt     <= '0;
            settle_cnt   <= 1'b0;
            presc        <= '0;
            tick_cnt     <= '0;
            l1_cnt       <= '0;
            first_l1     <= 1'b0;
            timeout_flag <= 1'b0;
            live         <= 1'b0;
            ena_delta    <= 1'b0;
            lv1          <= 1'b0;
            rpt_valid    <= 1'b0;
            rpt_delay    <= '0;
            rpt_timeout  <= 1'b0;
            rpt_lv1_cnt  <= '0;
        end else begin
            state        <= state_nxt;
            dead_cnt     <= dead_cnt_nxt;
            settle_cnt   <= settle_cnt_nxt;
            presc        <= presc_nxt;
            tick_cnt     <= tick_cnt_nxt;
            l1_cnt       <= l1_cnt_nxt;
            first_l1     <= first_l1_nxt;
            timeout_flag <= timeout_flag_nxt;
            live         <= live_nxt;
            ena_delta    <= ena_delta_nxt;
            lv1          <= lv1_nxt;
            rpt_valid    <= rpt_valid_nxt;
            rpt_delay    <= rpt_delay_nxt;
            rpt_timeout  <= rpt_timeout_nxt;
            rpt_lv1_cnt  <= rpt_lv1_cnt_nxt;
        end
    end

    // Next-state and next-output logic; outputs follow the state being entered.
    always_comb begin
        state_nxt        = state;
        dead_cnt_nxt     = dead_cnt;
        settle_cnt_nxt   = settle_cnt;
        presc_nxt        = presc;
        tick_cnt_nxt     = tick_cnt;
        l1_cnt_nxt       = l1_cnt;
        first_l1_nxt     = first_l1;
        timeout_flag_nxt = timeout_flag;
        rpt_delay_nxt    = rpt_delay;
        rpt_timeout_nxt  = rpt_timeout;
        rpt_lv1_cnt_nxt  = rpt_lv1_cnt;

        case (state)
            S_DEAD: begin
                if (dead_cnt == DEAD_LAST) begin
                    state_nxt    = S_IDLE;
                    dead_cnt_nxt = '0;
                end else begin
                    dead_cnt_nxt = dead_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (spill_on) begin
                    state_nxt        = S_LIVE;
                    presc_nxt        = '0;
                    tick_cnt_nxt     = '0;
                    l1_cnt_nxt       = '0;
                    first_l1_nxt     = 1'b0;
                    timeout_flag_nxt = 1'b0;
                end
            end
            S_LIVE: begin
                presc_nxt = (presc == PRE_LAST) ? '0 : presc + 1'b1;
                if (tick && !first_l1) begin
                    tick_cnt_nxt = tick_inc;
                end
                if (l1_fwd) begin
                    first_l1_nxt = 1'b1;
                    if (l1_cnt != 16'hFFFF) begin
                        l1_cnt_nxt = l1_cnt + 16'd1;
                    end
                end
                // An L1 on the same edge as the deciding tick suppresses the flag.
                if (tick && !first_l1 && !l1_fwd && !timeout_flag &&
                    (tick_inc >= TIMEOUT_TICKS)) begin
                    timeout_flag_nxt = 1'b1;
                end
                if (!spill_on) begin
                    state_nxt      = S_SETTLE;
                    settle_cnt_nxt = 1'b0;
                end
            end
            S_SETTLE: begin
                if (settle_cnt) begin
                    state_nxt       = S_REPORT;
                    rpt_delay_nxt   = meas_delay;
                    rpt_timeout_nxt = timeout_flag;
                    rpt_lv1_cnt_nxt = l1_cnt;
                end else begin
                    settle_cnt_nxt = 1'b1;
                end
            end
            S_REPORT: begin
                if (rpt_valid && rpt_ready) begin
                    state_nxt    = S_DEAD;
                    dead_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_DEAD;
            end
        endcase

        live_nxt      = (state_nxt == S_LIVE);
        ena_delta_nxt = tick;
        lv1_nxt       = l1_fwd;
        rpt_valid_nxt = (state_nxt == S_REPORT);
    end

endmodule

// File: tb/tb_lv1_delay_ctrl.sv
// tb_lv1_delay_ctrl: directed scenarios plus a randomized run, every cycle
// compared against a spill-level behavioural model of the sequencer.
module tb_lv1_delay_ctrl;

    localparam int DIV    = 4;
    localparam int CW     = 10;
    localparam int TO     = 12;
    localparam int DM     = 2;
    localparam int TO_CYC = TO * DIV;

    localparam int P_DEAD   = 0;
    localparam int P_IDLE   = 1;
    localparam int P_LIVE   = 2;
    localparam int P_SETTLE = 3;
    localparam int P_REPORT = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          spill_on   = 1'b0;
    logic          lv1_in     = 1'b0;
    logic          rpt_ready  = 1'b0;
    logic [CW-1:0] meas_delay = '0;
    logic          live, ena_delta, lv1, rpt_valid, rpt_timeout;
    logic [CW-1:0] rpt_delay;
    logic [15:0]   rpt_lv1_cnt;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // Model state: phase of the spill cycle, age within the live window,
    // first-L1 output age, and the expected outputs for the current cycle.
    int            m_phase = P_DEAD;
    int            m_cnt   = 0;
    int            m_age   = 0;
    int            m_len   = 0;
    int            m_first = -1;
    int            m_l1    = 0;
    logic          e_live  = 1'b0;
    logic          e_ena   = 1'b0;
    logic          e_lv1   = 1'b0;
    logic          e_valid = 1'b0;
    logic [CW-1:0] e_delay = '0;
    logic          e_to    = 1'b0;
    int            e_cnt   = 0;

    int n_live = 0, n_ena = 0, n_lv1 = 0, n_valid = 0, ena_at_l1 = 0;

    lv1_delay_ctrl #(
        .DELTA_DIV(DIV),
        .CNT_W    (CW),
        .TIMEOUT  (TO),
        .DEAD_MIN (DM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spill_on   (spill_on),
        .lv1_in     (lv1_in),
        .meas_delay (meas_delay),
        .live       (live),
        .ena_delta  (ena_delta),
        .lv1        (lv1),
        .rpt_valid  (rpt_valid),
        .rpt_delay  (rpt_delay),
        .rpt_timeout(rpt_timeout),
        .rpt_lv1_cnt(rpt_lv1_cnt),
        .rpt_ready  (rpt_ready)
    );

    // 100 MHz-style clock.
    initial forever #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural model: ena_delta is every DIV-th live cycle, lv1 is lv1_in
    // one cycle late, timeout is decided arithmetically at report time.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = P_DEAD; m_cnt = 0; m_age = 0; m_len = 0; m_first = -1; m_l1 = 0;
            e_live = 0; e_ena = 0; e_lv1 = 0; e_valid = 0; e_delay = '0; e_to = 0; e_cnt = 0;
        end else begin
            e_lv1 = (m_phase == P_LIVE) && lv1_in;
            case (m_phase)
                P_DEAD: begin
                    m_cnt++;
                    if (m_cnt == DM) m_phase = P_IDLE;
                end
                P_IDLE: begin
                    if (spill_on) begin
                        m_phase = P_LIVE; m_age = 0; m_l1 = 0; m_first = -1;
                    end
                end
                P_LIVE: begin
                    if (lv1_in) begin
                        if (m_l1 < 65535) m_l1++;
                        if (m_first < 0) m_first = m_age + 1;
                    end
                    if (!spill_on) begin
                        m_len = m_age + 1; m_phase = P_SETTLE; m_cnt = 0;
                    end else begin
                        m_age++;
                    end
                end
                P_SETTLE: begin
                    m_cnt++;
                    if (m_cnt == 2) begin
                        m_phase = P_REPORT;
                        e_delay = meas_delay;
                        e_to    = (TO_CYC < m_len) && ((m_first < 0) || (m_first > TO_CYC));
                        e_cnt   = m_l1;
                    end
                end
                P_REPORT: begin
                    if (rpt_ready) begin
                        m_phase = P_DEAD; m_cnt = 0;
                    end
                end
                default: m_phase = P_DEAD;
            endcase
            e_live  = (m_phase == P_LIVE);
            e_ena   = e_live && (m_age > 0) && ((m_age % DIV) == 0);
            e_valid = (m_phase == P_REPORT);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then compare every output at the falling edge.
    task automatic applyStimulus(input logic s, input logic l, input logic r, input logic [CW-1:0] d);
        spill_on   = s;
        lv1_in     = l;
        rpt_ready  = r;
        meas_delay = d;
        @(posedge clk);
        @(negedge clk);
        if (checking) begin
            checkOutput("live",        int'(live),        int'(e_live));
            checkOutput("ena_delta",   int'(ena_delta),   int'(e_ena));
            checkOutput("lv1",         int'(lv1),         int'(e_lv1));
            checkOutput("rpt_valid",   int'(rpt_valid),   int'(e_valid));
            checkOutput("rpt_delay",   int'(rpt_delay),   int'(e_delay));
            checkOutput("rpt_timeout", int'(rpt_timeout), int'(e_to));
            checkOutput("rpt_lv1_cnt", int'(rpt_lv1_cnt), e_cnt);
        end
        if (lv1) begin
            ena_at_l1 = n_ena;
            n_lv1++;
        end
        if (ena_delta) n_ena++;
        if (live) n_live++;
        if (rpt_valid) n_valid++;
    endtask

    task automatic waitLive(input logic [CW-1:0] d);
        int i = 0;
        while (!live && i < 20) begin
            applyStimulus(1'b1, 1'b0, 1'b0, d);
            i++;
        end
        checkOutput("live_rise", int'(live), 1);
    endtask

    // Starting in live cycle 0: run len live cycles, pulsing lv1_in at p0..p2.
    task automatic runSpill(input int len, input int p0, input int p1, input int p2, input logic [CW-1:0] d);
        for (int c = 0; c < len; c++)
            applyStimulus(c < len - 1, (c == p0) || (c == p1) || (c == p2), 1'b0, d);
    endtask

    task automatic waitReport(input logic [CW-1:0] d);
        int i = 0;
        while (!rpt_valid && i < 10) begin
            applyStimulus(1'b0, 1'b0, 1'b0, d);
            i++;
        end
        checkOutput("rpt_wait", int'(rpt_valid), 1);
    endtask

    task automatic gotoIdle();
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Main sequence: reset, directed spills, reset mid-spill, random traffic.
    initial begin
        int ena0, l10, l0, v0, gap;
        int t2_pos[3] = '{-1, TO_CYC - 1, TO_CYC};
        int t2_to[3]  = '{1, 0, 1};
        int t2_cnt[3] = '{0, 1, 1};
        logic s;

        #2 rst_n = 1'b0;
        #1;
        checking = 1'b1;
        checkOutput("rst_live",      int'(live),        0);
        checkOutput("rst_rpt_valid", int'(rpt_valid),   0);
        checkOutput("rst_rpt_cnt",   int'(rpt_lv1_cnt), 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        #2 rst_n = 1'b1;
        gotoIdle();

        // Single L1 at live cycle 41: ten ticks precede it, no timeout.
        waitLive(10'h123);
        ena0 = n_ena; l10 = n_lv1;
        runSpill(200, 41, -1, -1, 10'h123);
        waitReport(10'h123);
        checkOutput("t1_ena_before_lv1", ena_at_l1 - ena0, 10);
        checkOutput("t1_lv1_pulses", n_lv1 - l10, 1);
        checkOutput("t1_delay",   int'(rpt_delay),   'h123);
        checkOutput("t1_timeout", int'(rpt_timeout), 0);
        checkOutput("t1_cnt",     int'(rpt_lv1_cnt), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        gotoIdle();

        // Timeout: none, L1 on the deciding tick, L1 one cycle too late.
        for (int k = 0; k < 3; k++) begin
            waitLive(10'h2A5);
            runSpill(60, t2_pos[k], -1, -1, 10'h2A5);
            waitReport(10'h2A5);
            checkOutput($sformatf("t2_%0d_timeout", k), int'(rpt_timeout), t2_to[k]);
            checkOutput($sformatf("t2_%0d_cnt", k),     int'(rpt_lv1_cnt), t2_cnt[k]);
            applyStimulus(1'b0, 1'b0, 1'b1, '0);
            gotoIdle();
        end

        // One L1 while idle is dropped; three during live are forwarded.
        l10 = n_lv1;
        applyStimulus(1'b0, 1'b1, 1'b0, 10'h011);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h011);
        waitLive(10'h011);
        runSpill(30, 5, 10, 15, 10'h011);
        waitReport(10'h011);
        checkOutput("t3_lv1_pulses", n_lv1 - l10, 3);
        checkOutput("t3_cnt", int'(rpt_lv1_cnt), 3);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        gotoIdle();

        // Report stalled with spill_on high: live stays low, then dead time.
        waitLive(10'h077);
        runSpill(10, -1, -1, -1, 10'h077);
        waitReport(10'h077);
        l0 = n_live;
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 10'h077);
        checkOutput("t4_live_stall", n_live - l0, 0);
        checkOutput("t4_valid_held", int'(rpt_valid), 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h077);
        gap = 0;
        while (!live && gap < 20) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 10'h077);
            gap++;
        end
        checkOutput("t4_gap_min", int'(gap >= DM + 1), 1);
        checkOutput("t4_live_rise", int'(live), 1);
        runSpill(5, -1, -1, -1, 10'h077);
        waitReport(10'h077);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        gotoIdle();

        // One-cycle spill request gives exactly one live cycle and a report.
        l0 = n_live;
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h300);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h300);
        waitReport(10'h300);
        checkOutput("t6_live_cycles", n_live - l0, 1);
        checkOutput("t6_cnt", int'(rpt_lv1_cnt), 0);
        checkOutput("t6_delay", int'(rpt_delay), 'h300);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        gotoIdle();

        // Reset in the middle of a live window with ena_delta and lv1 active.
        waitLive(10'h155);
        for (int c = 0; c < 12; c++)
            applyStimulus(1'b1, c == 11, 1'b0, 10'h155);
        checkOutput("t5_pre_ena", int'(ena_delta), 1);
        checkOutput("t5_pre_lv1", int'(lv1), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_live",  int'(live),      0);
        checkOutput("t5_rst_ena",   int'(ena_delta), 0);
        checkOutput("t5_rst_lv1",   int'(lv1),       0);
        checkOutput("t5_rst_valid", int'(rpt_valid), 0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 10'h155);
        #2 rst_n = 1'b1;
        v0 = n_valid;
        repeat (30) applyStimulus(1'b0, 1'b0, 1'b1, 10'h155);
        checkOutput("t5_no_report", n_valid - v0, 0);
        waitLive(10'h0F0);
        runSpill(8, -1, -1, -1, 10'h0F0);
        waitReport(10'h0F0);
        checkOutput("t5_new_cnt", int'(rpt_lv1_cnt), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        gotoIdle();

        // Randomized spills, triggers and back-pressure.
        for (int i = 0; i < 4000; i++) begin
            s = spill_on ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 7) == 0);
            applyStimulus(s, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, CW'($urandom));
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
